// File: rtl/riscv_icache.sv
// Direct-mapped read-only instruction cache with 1-cycle hits and a valid/ready line refill port.
// Optional build macro ICACHE_PERF_EN adds hit_count_o / miss_count_o performance counters.
module riscv_icache #(
    parameter int          LINE_WORDS = 4,
    parameter int          NUM_LINES  = 64,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cpu_re_i,
    input  logic [31:0] cpu_addr_i,
    output logic [31:0] cpu_inst_o,
    output logic        cpu_stall_o,
    input  logic        inv_i,
    output logic        mem_req_valid_o,
    input  logic        mem_req_ready_i,
    output logic [31:0] mem_req_addr_o,
    input  logic        mem_resp_valid_i,
    input  logic [31:0] mem_resp_data_i
`ifdef ICACHE_PERF_EN
    , output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o
`endif
);

    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = 32 - 2 - OFF_W - IDX_W;
    localparam int ADDR_W = IDX_W + OFF_W;
    localparam int DEPTH  = NUM_LINES * LINE_WORDS;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_REPLAY} state_t;

    state_t             state_q, state_d;
    logic [31:0]        req_addr_q;
    logic               acc_q;
    logic               valid_rd_q;
    logic [TAG_W-1:0]   tag_rd_q;
    logic [31:0]        rd_data_q;
    logic               rep_q;
    logic [31:0]        inst_q;
    logic [31:0]        mem_addr_q;
    logic [OFF_W-1:0]   beat_q;
    logic               inv_pend_q;
    logic [NUM_LINES-1:0] valid_q;

    logic [31:0]        data_mem [DEPTH];
    logic [TAG_W-1:0]   tag_mem  [NUM_LINES];

    logic [IDX_W-1:0]   cpu_idx, req_idx;
    logic [OFF_W-1:0]   cpu_off, req_off;
    logic [TAG_W-1:0]   req_tag;
    logic [ADDR_W-1:0]  rd_addr;
    logic               accept, hit, miss, fill_we, last_beat;
    logic               unused_addr_bits;

    assign cpu_off = cpu_addr_i[2 +: OFF_W];
    assign cpu_idx = cpu_addr_i[2+OFF_W +: IDX_W];
    assign req_off = req_addr_q[2 +: OFF_W];
    assign req_idx = req_addr_q[2+OFF_W +: IDX_W];
    assign req_tag = req_addr_q[31 -: TAG_W];
    assign unused_addr_bits = ^{cpu_addr_i[1:0], req_addr_q[1:0]};

    assign accept    = cpu_re_i & ~cpu_stall_o;
    assign hit       = acc_q & valid_rd_q & (tag_rd_q == req_tag);
    assign miss      = acc_q & ~hit;
    assign fill_we   = (state_q == S_FILL) & mem_resp_valid_i;
    assign last_beat = fill_we & (beat_q == LAST_BEAT);
    // The replay re-reads the refilled word; otherwise the array follows the fetch address.
    assign rd_addr   = (state_q == S_REPLAY) ? {req_idx, req_off} : {cpu_idx, cpu_off};

    assign mem_req_addr_o = mem_addr_q;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d         = state_q;
        cpu_stall_o     = 1'b0;
        mem_req_valid_o = 1'b0;
        cpu_inst_o      = inst_q;
        unique case (state_q)
            S_IDLE: begin
                if (hit || rep_q) begin
                    cpu_inst_o = rd_data_q;
                end else if (miss) begin
                    cpu_stall_o = 1'b1;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                cpu_stall_o     = 1'b1;
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) state_d = S_FILL;
            end
            S_FILL: begin
                cpu_stall_o = 1'b1;
                if (last_beat) state_d = S_REPLAY;
            end
            S_REPLAY: begin
                cpu_stall_o = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            req_addr_q <= '0;
            acc_q      <= 1'b0;
            valid_rd_q <= 1'b0;
            rep_q      <= 1'b0;
            inst_q     <= NOP_INST;
            mem_addr_q <= '0;
            beat_q     <= '0;
            inv_pend_q <= 1'b0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= accept;
            rep_q      <= (state_q == S_REPLAY);
            inst_q     <= cpu_inst_o;
            // An invalidate in the acceptance cycle forces that lookup to miss.
            valid_rd_q <= valid_q[cpu_idx] & ~inv_i;
            if (accept) req_addr_q <= cpu_addr_i;
            if ((state_q == S_IDLE) && miss)
                mem_addr_q <= {req_addr_q[31:OFF_W+2], {(OFF_W+2){1'b0}}};
            if (fill_we) beat_q <= beat_q + 1'b1;

            if (state_q == S_REPLAY)
                inv_pend_q <= 1'b0;
            else if ((state_q != S_IDLE) && inv_i)
                inv_pend_q <= 1'b1;

            if ((state_q == S_IDLE) && inv_i)
                valid_q <= '0;
            else if ((state_q == S_REPLAY) && (inv_pend_q || inv_i))
                valid_q <= '0;
            else if (last_beat)
                valid_q[req_idx] <= 1'b1;
        end
    end

    // NOTE: data and tag arrays are not reset; valid_q alone decides whether their contents count.
    always_ff @(posedge clk_i) begin
        if (fill_we)   data_mem[{req_idx, beat_q}] <= mem_resp_data_i;
        if (last_beat) tag_mem[req_idx] <= req_tag;
        rd_data_q <= data_mem[rd_addr];
        tag_rd_q  <= tag_mem[cpu_idx];
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`endif

endmodule
